// File: rtl/load_hazard_controller_if.sv
// Hazard-control bus between the Decode/Execute stages and the hazard unit.
// The master side is the pipeline and drives the resolve, Execute and Decode
// information. The slave side is the hazard unit and returns the
// stall/bubble/flush controls and the performance counters.
//   clrStats                          : clear both performance counters
//   branch, takenBranch, prediction   : conditional-branch resolution
//   pcSrc                             : unconditional redirect
//   memReadE, writeRegisterE          : load flag and destination in Execute
//   rsD, rtD, useRsD, useRtD          : Decode source registers and usage
//   Stall, Bubble, Flush              : pipeline controls
//   stallCount, flushCount            : saturating event counters
interface load_hazard_controller_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             clrStats;
    logic             branch;
    logic             takenBranch;
    logic             prediction;
    logic             pcSrc;
    logic             memReadE;
    logic [REG_W-1:0] writeRegisterE;
    logic [REG_W-1:0] rsD;
    logic [REG_W-1:0] rtD;
    logic             useRsD;
    logic             useRtD;
    logic             Stall;
    logic             Bubble;
    logic             Flush;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    modport master (
        output clrStats, branch, takenBranch, prediction, pcSrc,
               memReadE, writeRegisterE, rsD, rtD, useRsD, useRtD,
        input  Stall, Bubble, Flush, stallCount, flushCount
    );

    modport slave (
        input  clrStats, branch, takenBranch, prediction, pcSrc,
               memReadE, writeRegisterE, rsD, rtD, useRsD, useRtD,
        output Stall, Bubble, Flush, stallCount, flushCount
    );
endinterface

// File: rtl/load_hazard_controller.sv
// Load-use hazard controller for loads with multi-cycle result latency.
// A load's destination blocks dependent Decode instructions while the load
// is in Execute, and for LOAD_LAT-1 further cycles. Those further cycles are
// tracked by a shift-register scoreboard. A redirect (mispredicted branch or
// jump) flushes IF/ID, and it suppresses the stall because the stalled
// instruction is being killed anyway.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   hz  : hazard bus (slave side); see load_hazard_controller_if
module load_hazard_controller #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input logic                    clk,
    input logic                    rst,
    load_hazard_controller_if.slave hz
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             loadValid_s;
    logic             pendRs_s;
    logic             pendRt_s;
    logic             matchRs_s;
    logic             matchRt_s;
    logic             hazard_s;
    logic             flushRaw_s;
    logic             stall_s;
    logic             flush_s;
    logic [CNT_W-1:0] stallCount_r;
    logic [CNT_W-1:0] flushCount_r;

    // A load to r0 never produces a value a consumer could wait on.
    assign loadValid_s = hz.memReadE && (hz.writeRegisterE != {REG_W{1'b0}});

    if (LOAD_LAT > 1) begin : gScoreboard
        logic [LOAD_LAT-2:0] pendValid_r;
        logic [REG_W-1:0]    pendReg_r [LOAD_LAT-1];

        // Scoreboard shift: Execute never stalls, so capture every cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                pendValid_r <= '0;
            end else begin
                pendValid_r[0] <= loadValid_s;
                pendReg_r[0]   <= hz.writeRegisterE;
                for (int k = 1; k < LOAD_LAT - 1; k++) begin
                    pendValid_r[k] <= pendValid_r[k-1];
                    pendReg_r[k]   <= pendReg_r[k-1];
                end
            end
        end

        // OR-reduce the scoreboard matches against both Decode sources.
        always_comb begin
            pendRs_s = 1'b0;
            pendRt_s = 1'b0;
            for (int k = 0; k < LOAD_LAT - 1; k++) begin
                pendRs_s = pendRs_s | (pendValid_r[k] && (pendReg_r[k] == hz.rsD));
                pendRt_s = pendRt_s | (pendValid_r[k] && (pendReg_r[k] == hz.rtD));
            end
        end
    end else begin : gNoScoreboard
        assign pendRs_s = 1'b0;
        assign pendRt_s = 1'b0;
    end

    // Scoreboard entries are only valid for nonzero registers. The explicit
    // r0 test still documents the rule for the Execute-stage match.
    assign matchRs_s = (hz.rsD != {REG_W{1'b0}}) &&
                       ((loadValid_s && (hz.rsD == hz.writeRegisterE)) || pendRs_s);
    assign matchRt_s = (hz.rtD != {REG_W{1'b0}}) &&
                       ((loadValid_s && (hz.rtD == hz.writeRegisterE)) || pendRt_s);
    assign hazard_s   = (hz.useRsD && matchRs_s) || (hz.useRtD && matchRt_s);
    assign flushRaw_s = ((hz.takenBranch ^ hz.prediction) & hz.branch) | hz.pcSrc;

    // Pipeline controls: forced idle during reset; a flush wins over a stall.
    always_comb begin
        if (rst) begin
            stall_s = 1'b0;
            flush_s = 1'b0;
        end else begin
            stall_s = hazard_s && !flushRaw_s;
            flush_s = flushRaw_s;
        end
    end

    assign hz.Stall  = stall_s;
    assign hz.Bubble = stall_s;
    assign hz.Flush  = flush_s;

    // Saturating performance counters; clrStats overrides a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || hz.clrStats) begin
            stallCount_r <= '0;
            flushCount_r <= '0;
        end else begin
            if (stall_s && (stallCount_r != {CNT_W{1'b1}})) begin
                stallCount_r <= stallCount_r + CNT_ONE;
            end else begin
                stallCount_r <= stallCount_r;
            end
            if (flush_s && (flushCount_r != {CNT_W{1'b1}})) begin
                flushCount_r <= flushCount_r + CNT_ONE;
            end else begin
                flushCount_r <= flushCount_r;
            end
        end
    end

    assign hz.stallCount = stallCount_r;
    assign hz.flushCount = flushCount_r;

endmodule

// File: tb/tb_load_hazard_controller.sv
// Bench for load_hazard_controller. Two instances share one stimulus stream:
// u1 uses LOAD_LAT=1 with 4-bit counters, and u3 uses LOAD_LAT=3 with 16-bit
// counters. A history model stores the Execute-stage content of recent cycles.
// It is checked against both instances on every falling edge. Literal
// counter checks at the end of each scenario pin the model itself.
module tb_load_hazard_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       clrStats, branch, takenBranch, prediction, pcSrc, memReadE;
    logic [4:0] writeRegisterE, rsD, rtD;
    logic       useRsD, useRtD;
    logic       armed = 1'b0;

    int errors = 0;
    int checks = 0;

    load_hazard_controller_if #(.REG_W(5), .CNT_W(4))  if1 ();
    load_hazard_controller_if #(.REG_W(5), .CNT_W(16)) if3 ();

    assign if1.clrStats = clrStats;       assign if3.clrStats = clrStats;
    assign if1.branch = branch;           assign if3.branch = branch;
    assign if1.takenBranch = takenBranch; assign if3.takenBranch = takenBranch;
    assign if1.prediction = prediction;   assign if3.prediction = prediction;
    assign if1.pcSrc = pcSrc;             assign if3.pcSrc = pcSrc;
    assign if1.memReadE = memReadE;       assign if3.memReadE = memReadE;
    assign if1.writeRegisterE = writeRegisterE;
    assign if3.writeRegisterE = writeRegisterE;
    assign if1.rsD = rsD;                 assign if3.rsD = rsD;
    assign if1.rtD = rtD;                 assign if3.rtD = rtD;
    assign if1.useRsD = useRsD;           assign if3.useRsD = useRsD;
    assign if1.useRtD = useRtD;           assign if3.useRtD = useRtD;

    load_hazard_controller #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .hz(if1)
    );
    load_hazard_controller #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .hz(if3)
    );

    // Model state: hv[j]/hr[j] = load in Execute j+1 cycles ago.
    bit         hv [3];
    logic [4:0] hr [3];
    int sc1 = 0, fc1 = 0, sc3 = 0, fc3 = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // A register is blocked if a load to it was in Execute within the last lat cycles.
    function automatic bit blocked(input logic [4:0] r, input int lat);
        if (r == 5'd0) return 1'b0;
        if (memReadE && writeRegisterE == r) return 1'b1;
        for (int j = 0; j < lat - 1; j++)
            if (hv[j] && hr[j] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit hazardM(input int lat);
        return (useRsD && blocked(rsD, lat)) || (useRtD && blocked(rtD, lat));
    endfunction

    function automatic bit flushM();
        return ((takenBranch ^ prediction) & branch) | pcSrc;
    endfunction

    // Model update on the same edge as the DUT.
    always @(posedge clk) begin
        bit fl, st1, st3;
        if (rst) begin
            for (int j = 0; j < 3; j++) hv[j] = 1'b0;
            sc1 = 0; fc1 = 0; sc3 = 0; fc3 = 0;
        end else begin
            fl  = flushM();
            st1 = hazardM(1) && !fl;
            st3 = hazardM(3) && !fl;
            if (clrStats) begin
                sc1 = 0; fc1 = 0; sc3 = 0; fc3 = 0;
            end else begin
                if (st1 && sc1 < 15) sc1++;
                if (fl && fc1 < 15) fc1++;
                if (st3 && sc3 < 65535) sc3++;
                if (fl && fc3 < 65535) fc3++;
            end
            hv[2] = hv[1]; hr[2] = hr[1];
            hv[1] = hv[0]; hr[1] = hr[0];
            hv[0] = memReadE && (writeRegisterE != 5'd0);
            hr[0] = writeRegisterE;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        bit fl, st1, st3;
        if (armed) begin
            fl  = rst ? 1'b0 : flushM();
            st1 = rst ? 1'b0 : (hazardM(1) && !fl);
            st3 = rst ? 1'b0 : (hazardM(3) && !fl);
            chk("u1.Stall", {31'd0, if1.Stall}, {31'd0, st1});
            chk("u1.Bubble", {31'd0, if1.Bubble}, {31'd0, st1});
            chk("u1.Flush", {31'd0, if1.Flush}, {31'd0, fl});
            chk("u1.stallCount", {28'd0, if1.stallCount}, sc1);
            chk("u1.flushCount", {28'd0, if1.flushCount}, fc1);
            chk("u3.Stall", {31'd0, if3.Stall}, {31'd0, st3});
            chk("u3.Bubble", {31'd0, if3.Bubble}, {31'd0, st3});
            chk("u3.Flush", {31'd0, if3.Flush}, {31'd0, fl});
            chk("u3.stallCount", {16'd0, if3.stallCount}, sc3);
            chk("u3.flushCount", {16'd0, if3.flushCount}, fc3);
        end
    end

    task automatic step(input logic mr, input logic [4:0] wr, input logic [4:0] rs,
                        input logic urs, input logic [4:0] rt, input logic urt,
                        input logic br, input logic tk, input logic pd, input logic pc);
        memReadE = mr; writeRegisterE = wr; rsD = rs; useRsD = urs; rtD = rt; useRtD = urt;
        branch = br; takenBranch = tk; prediction = pd; pcSrc = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clrStats = 1'b0;
        memReadE = 1'b0; writeRegisterE = 5'd0; rsD = 5'd0; rtD = 5'd0;
        useRsD = 1'b0; useRtD = 1'b0;
        branch = 1'b0; takenBranch = 1'b0; prediction = 1'b0; pcSrc = 1'b0;
        @(posedge clk); #1;
        armed = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset stallCount", {16'd0, if3.stallCount}, 32'd0);
        chk("reset flushCount", {16'd0, if3.flushCount}, 32'd0);

        // Consumer directly behind load r5: 1 stall on u1, 3 stalls on u3.
        step(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("lat1 single stall", {28'd0, if1.stallCount}, 32'd1);
        chk("lat3 direct stall", {16'd0, if3.stallCount}, 32'd3);

        // Consumer two behind load r7: 2 stalls on u3 only.
        step(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lat3 two-behind", {16'd0, if3.stallCount}, 32'd5);

        // r0 load with r0 user; load r4 with rt=r4 unused: no stalls.
        step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(); idle();
        chk("r0/unused no stall", {16'd0, if3.stallCount}, 32'd5);

        // Mispredict during hazard, then pcSrc alone.
        step(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(); idle();
        chk("flush count", {28'd0, if1.flushCount}, 32'd2);
        chk("flush beats stall", {28'd0, if1.stallCount}, 32'd1);

        // Flush arriving mid-stall on u3; scoreboard keeps shifting.
        step(1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("mid-stall flush", {16'd0, if3.stallCount}, 32'd7);

        // Back-to-back loads to r3; rt user then stalls 2 cycles on u3.
        step(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("back-to-back", {16'd0, if3.stallCount}, 32'd9);

        // Reset during a stall, then the old load register no longer blocks.
        step(1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("post-reset no stall", {16'd0, if3.stallCount}, 32'd0);

        // Saturation: 2^4+5 stall cycles on the 4-bit counter.
        for (int i = 0; i < 21; i++)
            step(1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("saturated", {28'd0, if1.stallCount}, 32'd15);
        chk("wide count", {16'd0, if3.stallCount}, 32'd21);
        clrStats = 1'b1;
        step(1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clrStats = 1'b0;
        chk("clrStats u1", {28'd0, if1.stallCount}, 32'd0);
        chk("clrStats u3", {16'd0, if3.stallCount}, 32'd0);
        idle(); idle(); idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
